// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the MIPS fetch front end.
//   INSTR_NOP           : all-zero instruction placed in IF/ID bubbles
//   DEFAULT_RESET_PC    : default PC loaded by reset
//   DEFAULT_IRQ_VECTOR  : default interrupt entry PC
//   btb_ctr_e           : 2-bit saturating branch counter encodings
//   ctrInc / ctrDec     : saturating counter helpers
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [31:0] INSTR_NOP          = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_IRQ_VECTOR = 32'h8000_0004;

    // Bit 1 of the counter is the taken/not-taken prediction
    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } btb_ctr_e;

    // Step a counter toward strongly-taken, sticking at ST
    function automatic btb_ctr_e ctrInc(input btb_ctr_e c);
        logic [1:0] raw;
        raw = c;
        return (c == ST) ? ST : btb_ctr_e'(raw + 2'd1);
    endfunction

    // Step a counter toward strongly-not-taken, sticking at SNT
    function automatic btb_ctr_e ctrDec(input btb_ctr_e c);
        logic [1:0] raw;
        raw = c;
        return (c == SNT) ? SNT : btb_ctr_e'(raw - 2'd1);
    endfunction

endpackage

// File: rtl/fetch_btb.sv
// ----------------------------------------------------------------------------
// fetch_btb
// Direct-mapped branch target buffer with 2-bit saturating counters.
//   clk_i, reset_ni          : clock, synchronous active-low reset
//   lookupPc_i               : PC being fetched (combinational lookup)
//   predTaken_o/predTarget_o : prediction for lookupPc_i
//   updValid_i, updPc_i,
//   updTaken_i, updTarget_i  : resolved-branch training port
// Lookups see the contents from before any same-edge update.
// ----------------------------------------------------------------------------
module fetch_btb
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic [XLEN-1:0] lookupPc_i,
    output logic            predTaken_o,
    output logic [XLEN-1:0] predTarget_o,
    input  logic            updValid_i,
    input  logic [XLEN-1:0] updPc_i,
    input  logic            updTaken_i,
    input  logic [XLEN-1:0] updTarget_i
);

    localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
    localparam int unsigned TAGW = XLEN - IDX - 2;

    logic            valid_q  [BTB_ENTRIES];
    logic [TAGW-1:0] tag_q    [BTB_ENTRIES];
    btb_ctr_e        ctr_q    [BTB_ENTRIES];
    logic [XLEN-1:0] target_q [BTB_ENTRIES];

    logic [IDX-1:0]  lkIdx;
    logic [TAGW-1:0] lkTag;
    logic            lkHit;
    logic [IDX-1:0]  updIdx;
    logic [TAGW-1:0] updTag;
    logic            updHit;
    logic            unusedByteBits;

    // Instructions are word aligned, so the byte-offset bits never take part
    assign unusedByteBits = ^{lookupPc_i[1:0], updPc_i[1:0]};

    // Combinational lookup on the fetch PC
    always_comb begin
        lkIdx        = lookupPc_i[IDX+1:2];
        lkTag        = lookupPc_i[XLEN-1:IDX+2];
        lkHit        = valid_q[lkIdx] && (tag_q[lkIdx] == lkTag);
        predTaken_o  = lkHit && ctr_q[lkIdx][1];
        predTarget_o = target_q[lkIdx];
    end

    // Hit detection for the training port
    always_comb begin
        updIdx = updPc_i[IDX+1:2];
        updTag = updPc_i[XLEN-1:IDX+2];
        updHit = valid_q[updIdx] && (tag_q[updIdx] == updTag);
    end

    // Training: hits move the counter (and refresh the target when taken),
    // taken misses allocate over whatever alias occupied the slot, and
    // not-taken misses are dropped. Reset only needs to clear valid bits.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (updValid_i) begin
            if (updHit) begin
                if (updTaken_i) begin
                    ctr_q[updIdx]    <= ctrInc(ctr_q[updIdx]);
                    target_q[updIdx] <= updTarget_i;
                end else begin
                    ctr_q[updIdx] <= ctrDec(ctr_q[updIdx]);
                end
            end else if (updTaken_i) begin
                valid_q[updIdx]  <= 1'b1;
                tag_q[updIdx]    <= updTag;
                ctr_q[updIdx]    <= WT;
                target_q[updIdx] <= updTarget_i;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch front end: PC, next-PC priority mux, IF/ID register,
// dynamic branch prediction via fetch_btb, interrupt vectoring with EPC.
//   clk_i, reset_ni      : clock, synchronous active-low reset
//   imem_addr_o          : fetch address (= PC)
//   imem_rdata_i         : instruction at imem_addr_o, same cycle
//   stall_i              : hold PC and IF/ID
//   redirect_valid_i/pc  : correction from ID/EX, beats stall
//   irq_i                : level interrupt request
//   irq_ack_o, epc_o     : taken-interrupt pulse and return PC
//   upd_*                : BTB training from EX
//   if_id_*              : IF/ID pipeline register contents
// ----------------------------------------------------------------------------
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEFAULT_RESET_PC),
    parameter logic [XLEN-1:0] IRQ_VECTOR  = XLEN'(DEFAULT_IRQ_VECTOR)
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [31:0]     imem_rdata_i,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            irq_i,
    output logic            irq_ack_o,
    output logic [XLEN-1:0] epc_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i,
    output logic            if_id_valid_o,
    output logic [31:0]     if_id_instr_o,
    output logic [XLEN-1:0] if_id_pc_plus_4_o,
    output logic            if_id_pred_taken_o,
    output logic [XLEN-1:0] if_id_pred_target_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            irqAck_q, irqAck_d;
    logic            ifIdValid_q, ifIdValid_d;
    logic [31:0]     ifIdInstr_q, ifIdInstr_d;
    logic [XLEN-1:0] ifIdPcPlus4_q, ifIdPcPlus4_d;
    logic            ifIdPredTaken_q, ifIdPredTaken_d;
    logic [XLEN-1:0] ifIdPredTarget_q, ifIdPredTarget_d;

    logic            predTaken;
    logic [XLEN-1:0] predTarget;
    logic [XLEN-1:0] pcPlus4;

    fetch_btb #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) btb (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .lookupPc_i   (pc_q),
        .predTaken_o  (predTaken),
        .predTarget_o (predTarget),
        .updValid_i   (upd_valid_i),
        .updPc_i      (upd_pc_i),
        .updTaken_i   (upd_taken_i),
        .updTarget_i  (upd_target_i)
    );

    // Sequential PC increment wraps silently at the top of the address space
    assign pcPlus4 = pc_q + XLEN'(4);

    // Next-PC priority: redirect, then interrupt (only when not stalled),
    // then stall hold, then predicted target or fall-through. Both redirect
    // and interrupt squash IF/ID into a bubble; irq_ack only pulses for the
    // cycle following the edge on which the interrupt was accepted.
    always_comb begin
        pc_d             = pc_q;
        epc_d            = epc_q;
        irqAck_d         = 1'b0;
        ifIdValid_d      = ifIdValid_q;
        ifIdInstr_d      = ifIdInstr_q;
        ifIdPcPlus4_d    = ifIdPcPlus4_q;
        ifIdPredTaken_d  = ifIdPredTaken_q;
        ifIdPredTarget_d = ifIdPredTarget_q;
        if (redirect_valid_i || (irq_i && !stall_i)) begin
            ifIdValid_d      = 1'b0;
            ifIdInstr_d      = INSTR_NOP;
            ifIdPcPlus4_d    = '0;
            ifIdPredTaken_d  = 1'b0;
            ifIdPredTarget_d = '0;
            if (redirect_valid_i) begin
                pc_d = redirect_pc_i;
            end else begin
                pc_d     = IRQ_VECTOR;
                epc_d    = pc_q;
                irqAck_d = 1'b1;
            end
        end else if (!stall_i) begin
            pc_d             = predTaken ? predTarget : pcPlus4;
            ifIdValid_d      = 1'b1;
            ifIdInstr_d      = imem_rdata_i;
            ifIdPcPlus4_d    = pcPlus4;
            ifIdPredTaken_d  = predTaken;
            ifIdPredTarget_d = predTaken ? predTarget : '0;
        end
    end

    // State registers; reset forces a bubble and the reset PC
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            pc_q             <= RESET_PC;
            epc_q            <= '0;
            irqAck_q         <= 1'b0;
            ifIdValid_q      <= 1'b0;
            ifIdInstr_q      <= INSTR_NOP;
            ifIdPcPlus4_q    <= '0;
            ifIdPredTaken_q  <= 1'b0;
            ifIdPredTarget_q <= '0;
        end else begin
            pc_q             <= pc_d;
            epc_q            <= epc_d;
            irqAck_q         <= irqAck_d;
            ifIdValid_q      <= ifIdValid_d;
            ifIdInstr_q      <= ifIdInstr_d;
            ifIdPcPlus4_q    <= ifIdPcPlus4_d;
            ifIdPredTaken_q  <= ifIdPredTaken_d;
            ifIdPredTarget_q <= ifIdPredTarget_d;
        end
    end

    assign imem_addr_o         = pc_q;
    assign irq_ack_o           = irqAck_q;
    assign epc_o               = epc_q;
    assign if_id_valid_o       = ifIdValid_q;
    assign if_id_instr_o       = ifIdInstr_q;
    assign if_id_pc_plus_4_o   = ifIdPcPlus4_q;
    assign if_id_pred_taken_o  = ifIdPredTaken_q;
    assign if_id_pred_target_o = ifIdPredTarget_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end for the 5-stage MIPS pipeline. It owns the PC, the IF/ID pipeline register and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. Static predict-not-taken is replaced by dynamic prediction, and the block adds interrupt vectoring with EPC capture. ID/EX resolve jumps and branches and report back through the redirect and update ports.

Parameters:
XLEN, 32, PC and data width.
BTB_ENTRIES, 16, BTB depth; power of two, at least 2; IDX = log2(BTB_ENTRIES).
RESET_PC, 32'h0000_0000, PC loaded by reset.
IRQ_VECTOR, 32'h8000_0004, interrupt entry PC.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-low reset.
imem_addr  out  XLEN  fetch address, equal to PC; instruction memory is combinational.
imem_rdata  in  32  instruction at imem_addr, same cycle.
stall  in  1  from hazard unit: hold PC and IF/ID.
redirect_valid  in  1  ID jump/jr or EX mispredict correction.
redirect_pc  in  XLEN  corrected next PC.
irq  in  1  level-sensitive interrupt request.
irq_ack  out  1  one-cycle pulse when the interrupt is taken.
epc  out  XLEN  return PC latched when the interrupt is taken.
upd_valid  in  1  EX resolved a branch this cycle.
upd_pc  in  XLEN  PC of the resolved branch.
upd_taken  in  1  actual outcome.
upd_target  in  XLEN  actual taken target.
if_id_valid  out  1  IF/ID holds a real instruction.
if_id_instr  out  32  IF/ID instruction; 0 (NOP) when not valid.
if_id_pc_plus_4  out  XLEN  PC+4 of the IF/ID instruction.
if_id_pred_taken  out  1  prediction made at fetch.
if_id_pred_target  out  XLEN  predicted target (valid only if pred_taken).

Behaviour:
- Reset (reset==0 at a clock edge):
  - PC=RESET_PC; all BTB valid bits cleared.
  - IF/ID becomes a bubble: valid=0, instr=0, pc_plus_4=0, pred_taken=0, pred_target=0.
  - irq_ack=0; epc=0.
  - Reset overrides all other inputs. Mid-stream reset discards any in-flight redirect or update.
- BTB entry fields: valid, tag = PC[XLEN-1:IDX+2], 2-bit counter, target[XLEN-1:0]. Index = PC[IDX+1:2].
- Lookup (combinational on PC):
  - hit = valid && tag match.
  - pred_taken = hit && counter[1].
  - pred_target = entry target.
- Next-PC priority, evaluated each cycle:
  1. redirect_valid: PC<=redirect_pc. IF/ID<=bubble. Applies even when stall=1.
  2. irq && !stall: PC<=IRQ_VECTOR; epc<=PC; irq_ack=1 for that cycle; IF/ID<=bubble.
  3. stall: PC and IF/ID hold.
  4. pred_taken: PC<=pred_target; IF/ID<=fetched instruction with pred_taken=1.
  5. Otherwise: PC<=PC+4; IF/ID<=fetched instruction.
- PC+4 is computed modulo 2^XLEN and wraps silently.
- irq is ignored while redirect_valid=1 or stall=1; it is re-evaluated on the next cycle.
- Update, when upd_valid=1 at an edge:
  - Hit, taken: counter saturates upward at 3; target<=upd_target.
  - Hit, not taken: counter saturates downward at 0; target is unchanged.
  - Miss, taken: allocate the entry (overwriting any alias) with valid=1, the new tag, counter=2 (weakly taken), target=upd_target.
  - Miss, not taken: no change.
- Updates are applied regardless of stall and redirect_valid. Reset is the only thing that suppresses them.
- Same-cycle lookup and update of the same entry: the prediction uses the pre-update contents (read-before-write).
- Latency: one cycle from PC to IF/ID. Redirect to the first valid IF/ID instruction is 2 cycles.

Decomposition:
- Shared package cpu_pkg:
  - INSTR_NOP = 32'h0.
  - Counter encodings SNT=0, WNT=1, WT=2, ST=3.
  - Default vectors RESET_PC and IRQ_VECTOR.
- Sub-module fetch_btb:
  - Holds the entry storage, combinational lookup, saturating update and allocation.
  - Parametrised by XLEN and BTB_ENTRIES.
- fetch_unit keeps the PC, the next-PC priority mux, IF/ID and the irq/epc logic.

Test Plan:
- Reset, then release with imem returning instr=0x20080001 at every address → PC runs 0,4,8; if_id_valid=1 from the cycle after release; if_id_pc_plus_4=4,8,12.
- stall=1 for 3 cycles at PC=0x10 → PC stays 0x10 and IF/ID is unchanged; release → PC=0x14.
- Update pc=0x20, taken, target 0x100 twice, then fetch 0x20 → pred_taken=1; next PC=0x100; counter=3. Two not-taken updates → fetch 0x20 predicts not taken.
- redirect_valid=1, redirect_pc=0x40, together with stall=1 and irq=1 → PC=0x40; IF/ID bubble; irq_ack=0. irq taken the next cycle: PC=0x8000_0004, epc=0x40, irq_ack pulses once.
- BTB_ENTRIES=16: taken update at 0x20, then a taken update at 0x60 (same index) → 0x60 evicts 0x20; fetch 0x20 → pred_taken=0.
- Same-edge update and lookup of 0x20 (miss→allocate) → that fetch predicts not taken; the next fetch of 0x20 predicts taken.
